// File: rtl/pe_pkg.sv
// Shared definitions for the PE accumulator read-out path: drain FSM state
// encoding, default lane widths and the beat-count helper.
package pe_pkg;

  // Drain FSM: IDLE waits for a finished accumulation, SEND streams beats.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Default output lane width and the matching accumulator lane width.
  localparam int PE_DATA_WIDTH = 8;
  localparam int ACC_WIDTH     = 2 * PE_DATA_WIDTH;

  // Number of output beats needed to stream every accumulator lane.
  function automatic int calc_beats(input int copies, input int lanes);
    return copies / lanes;
  endfunction

endpackage

// File: rtl/pe_requant.sv
// Single-lane requantizer: arithmetic right shift with round-half-up,
// optional ReLU, then saturation to a signed DATA_WIDTH result.
// Purely combinational.
module pe_requant
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int SHIFT_W    = 4
) (
  input  logic signed [2*DATA_WIDTH-1:0] i_acc,
  input  logic        [SHIFT_W-1:0]      i_shift,
  input  logic                           i_relu_en,
  output logic signed [DATA_WIDTH-1:0]   o_q
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  // One guard bit so the rounding bias can never wrap the accumulator value.
  localparam int EXT_W = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - EXT_W'(1);

  // Add half an LSB of the shifted result, then shift arithmetically.
  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [ACC_W-1:0]   x,
    input logic        [SHIFT_W-1:0] s
  );
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] bias;
    ext  = {x[ACC_W-1], x};
    bias = '0;
    if (s != '0) begin
      bias = EXT_W'(1) <<< (s - 1'b1);
    end
    return (ext + bias) >>> s;
  endfunction

  // Clamp negative values to zero when ReLU is enabled.
  function automatic logic signed [EXT_W-1:0] relu(
    input logic signed [EXT_W-1:0] v,
    input logic                    en
  );
    if (en && v[EXT_W-1]) begin
      return '0;
    end
    return v;
  endfunction

  // Saturate to the signed output range.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(
    input logic signed [EXT_W-1:0] v
  );
    logic signed [EXT_W-1:0] c;
    if (v > MAX_V) begin
      c = MAX_V;
    end else if (v < MIN_V) begin
      c = MIN_V;
    end else begin
      c = v;
    end
    return c[DATA_WIDTH-1:0];
  endfunction

  // Full requantization chain for this lane.
  always_comb begin
    o_q = saturate(relu(round_shift(i_acc, i_shift), i_relu_en));
  end

endmodule

// File: rtl/pe_acc_drain.sv
// Read-out end of the PE accumulator array. Snapshots all accumulator lanes
// when accumulation completes, clears the accumulator on the same edge, and
// streams requantized lanes OUT_LANES per beat over valid/ready. A done that
// lines up with the final handshake recaptures without an idle bubble; a
// done arriving at any other point of a drain is dropped and flagged.
module pe_acc_drain
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int OUT_LANES   = 8,
  parameter int SHIFT_W     = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_acc_result,
  input  logic                                i_acc_done,
  input  logic [SHIFT_W-1:0]                  i_shift,
  input  logic                                i_relu_en,
  output logic                                o_acc_clear,
  output logic [OUT_LANES*DATA_WIDTH-1:0]     o_data,
  output logic                                o_data_vld,
  input  logic                                i_data_rdy,
  output logic                                o_data_last,
  output logic                                o_busy,
  output logic                                o_drop
);

  localparam int ACC_W     = 2 * DATA_WIDTH;
  localparam int BEATS     = calc_beats(DATA_COPIES, OUT_LANES);
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BITS = OUT_LANES * ACC_W;

  if ((DATA_COPIES % OUT_LANES) != 0) begin : g_bad_lanes
    $error("pe_acc_drain: DATA_COPIES must be a multiple of OUT_LANES");
  end

  state_e                         state_q,  state_d;
  logic [BEAT_W-1:0]              beat_q,   beat_d;
  logic [DATA_COPIES*ACC_W-1:0]   shadow_q, shadow_d;
  logic [SHIFT_W-1:0]             shift_q,  shift_d;
  logic                           relu_q,   relu_d;
  logic                           drop_q,   drop_d;

  logic                           is_send;
  logic                           last_beat;
  logic                           handshake;
  logic                           accept;
  logic [BEAT_BITS-1:0]           beat_lanes;
  logic [OUT_LANES*DATA_WIDTH-1:0] data_w;

  assign is_send   = (state_q == ST_SEND);
  assign last_beat = is_send && (beat_q == BEAT_W'(BEATS - 1));
  assign handshake = is_send && i_data_rdy;
  // A new snapshot fits only when idle or when the final beat leaves this cycle.
  assign accept    = i_acc_done && (!is_send || (handshake && last_beat));

  assign o_acc_clear = accept;
  assign o_data_vld  = is_send;
  assign o_data_last = last_beat;
  assign o_busy      = is_send;
  assign o_drop      = drop_q;
  assign o_data      = data_w;

  // Next-state logic: capture on accept, otherwise advance on each handshake.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    drop_d   = i_acc_done && !accept;
    if (accept) begin
      shadow_d = i_acc_result;
      shift_d  = i_shift;
      relu_d   = i_relu_en;
      beat_d   = '0;
      state_d  = ST_SEND;
    end else if (handshake) begin
      if (last_beat) begin
        beat_d  = '0;
        state_d = ST_IDLE;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  // State, beat counter, snapshot and drop flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      shadow_q <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      relu_q   <= relu_d;
      drop_q   <= drop_d;
    end
  end

  // Select the group of shadow lanes belonging to the current beat.
  always_comb begin
    beat_lanes = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        beat_lanes = shadow_q[b*BEAT_BITS +: BEAT_BITS];
      end
    end
  end

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
    pe_requant #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_W    (SHIFT_W)
    ) u_requant (
      .i_acc     (beat_lanes[j*ACC_W +: ACC_W]),
      .i_shift   (shift_q),
      .i_relu_en (relu_q),
      .o_q       (data_w[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pe_acc_drain.sv
// Bench for pe_acc_drain: directed scenarios followed by randomized traffic,
// all outputs checked by a scoreboard fed from an arithmetic reference model.
module tb_pe_acc_drain;

  localparam int DW     = 8;
  localparam int COPIES = 32;
  localparam int LANES  = 8;
  localparam int SW     = 4;
  localparam int ACC_W  = 2 * DW;
  localparam int BEATS  = COPIES / LANES;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [COPIES*ACC_W-1:0]   acc_result = '0;
  logic                      acc_done = 1'b0;
  logic [SW-1:0]             shift = '0;
  logic                      relu_en = 1'b0;
  logic                      data_rdy = 1'b0;
  logic                      acc_clear;
  logic [LANES*DW-1:0]       data;
  logic                      data_vld;
  logic                      data_last;
  logic                      busy;
  logic                      drop;

  pe_acc_drain #(
    .DATA_WIDTH (DW),
    .DATA_COPIES(COPIES),
    .OUT_LANES  (LANES),
    .SHIFT_W    (SW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_acc_result(acc_result),
    .i_acc_done  (acc_done),
    .i_shift     (shift),
    .i_relu_en   (relu_en),
    .o_acc_clear (acc_clear),
    .o_data      (data),
    .o_data_vld  (data_vld),
    .i_data_rdy  (data_rdy),
    .o_data_last (data_last),
    .o_busy      (busy),
    .o_drop      (drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [LANES*DW-1:0] data;
    logic                last;
  } beat_t;

  beat_t exp_q[$];
  logic  drop_exp = 1'b0;
  logic  mon_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requantization in plain integer arithmetic.
  function automatic logic [DW-1:0] ref_lane(input longint x, input int s, input bit r);
    longint v;
    longint hi;
    longint lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    v  = x;
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (r && v < 0) v = 0;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v[DW-1:0];
  endfunction

  // Expected beat stream for one accepted snapshot.
  task automatic push_snapshot(input logic [COPIES*ACC_W-1:0] d, input int s, input bit r);
    for (int b = 0; b < BEATS; b++) begin
      beat_t bt;
      bt.last = (b == BEATS - 1);
      bt.data = '0;
      for (int j = 0; j < LANES; j++) begin
        logic [ACC_W-1:0] raw;
        raw = d[(b*LANES + j)*ACC_W +: ACC_W];
        bt.data[j*DW +: DW] = ref_lane(longint'($signed(raw)), s, r);
      end
      exp_q.push_back(bt);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, pops on handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      drop_exp = 1'b0;
      chk("rst_vld",   64'(data_vld),  64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_last",  64'(data_last), 64'd0);
      chk("rst_drop",  64'(drop),      64'd0);
      chk("rst_data",  64'(data),      64'd0);
      chk("rst_clear", 64'(acc_clear), 64'd0);
    end else begin
      chk("vld",  64'(data_vld), 64'(exp_q.size() != 0));
      chk("busy", 64'(busy),     64'(exp_q.size() != 0));
      if (data_vld && exp_q.size() != 0) begin
        chk("beat_data", 64'(data),      64'(exp_q[0].data));
        chk("beat_last", 64'(data_last), 64'(exp_q[0].last));
      end
      mon_acc = acc_done && (exp_q.size() == 0 || (exp_q.size() == 1 && data_rdy));
      chk("acc_clear", 64'(acc_clear), 64'(mon_acc));
      chk("drop",      64'(drop),      64'(drop_exp));
      drop_exp = acc_done && !mon_acc;
      if (exp_q.size() != 0 && data_rdy) void'(exp_q.pop_front());
      if (mon_acc) push_snapshot(acc_result, int'(shift), relu_en);
    end
  end

  function automatic logic [COPIES*ACC_W-1:0] rand_data();
    logic [COPIES*ACC_W-1:0] d;
    for (int i = 0; i < COPIES; i++) begin
      logic [ACC_W-1:0] v;
      v = ACC_W'($urandom);
      if ($urandom_range(7) == 0) v = ($urandom_range(1) == 1) ? 16'h7FFF : 16'h8000;
      d[i*ACC_W +: ACC_W] = v;
    end
    return d;
  endfunction

  // Wait (bounded) for the drain to finish, then issue a one-cycle done.
  // Entered and left at 1 time unit after a rising edge.
  task automatic snap(input logic [COPIES*ACC_W-1:0] d, input logic [SW-1:0] s, input logic r);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_before_done", 64'(busy), 64'd0);
    acc_result = d;
    shift      = s;
    relu_en    = r;
    acc_done   = 1'b1;
    #2;
    chk("clear_on_accept", 64'(acc_clear), 64'd1);
    @(posedge clk); #1;
    acc_done   = 1'b0;
    acc_result = rand_data();
    shift      = SW'($urandom);
    relu_en    = 1'($urandom);
    chk("vld_latency", 64'(data_vld), 64'd1);
  endtask

  logic [COPIES*ACC_W-1:0] d_basic;
  logic [COPIES*ACC_W-1:0] d_round;
  logic [COPIES*ACC_W-1:0] d_sat;
  logic [COPIES*ACC_W-1:0] d_relu;
  logic [LANES*DW-1:0]     held_data;
  logic                    held_last;

  initial begin
    for (int i = 0; i < COPIES; i++) d_basic[i*ACC_W +: ACC_W] = ACC_W'(i - 16);
    d_round = '0;
    d_round[0*ACC_W +: ACC_W] = 16'd300;
    d_round[1*ACC_W +: ACC_W] = 16'hFFFB;
    d_sat = '0;
    d_sat[2*ACC_W +: ACC_W] = 16'h7FFF;
    d_sat[3*ACC_W +: ACC_W] = 16'h8000;
    d_sat[4*ACC_W +: ACC_W] = 16'h8000;
    d_relu = '0;
    d_relu[0*ACC_W +: ACC_W] = 16'hFF38;
    d_relu[1*ACC_W +: ACC_W] = 16'd200;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    data_rdy = 1'b1;
    @(posedge clk); #1;

    // Basic drain: lanes hold i-16.
    snap(d_basic, 4'd0, 1'b0);
    chk("basic_b0_l0", 64'(data[7:0]), 64'hF0);
    chk("basic_b0_last", 64'(data_last), 64'd0);
    for (int b = 1; b < BEATS; b++) begin
      @(posedge clk); #1;
      chk("basic_last", 64'(data_last), 64'(b == BEATS - 1));
    end
    chk("basic_b3_l7", 64'(data[63:56]), 64'h0F);

    // Rounding and saturation.
    snap(d_round, 4'd1, 1'b0);
    chk("round_300_s1", 64'(data[7:0]),  64'h7F);
    chk("round_m5_s1",  64'(data[15:8]), 64'hFE);
    snap(d_sat, 4'd0, 1'b0);
    chk("sat_7fff_s0", 64'(data[23:16]), 64'h7F);
    chk("sat_8000_s0", 64'(data[39:32]), 64'h80);
    snap(d_sat, 4'd15, 1'b0);
    chk("sat_8000_s15", 64'(data[31:24]), 64'hFF);

    // ReLU.
    snap(d_relu, 4'd2, 1'b1);
    chk("relu_m200", 64'(data[7:0]),  64'h00);
    chk("relu_200",  64'(data[15:8]), 64'h32);

    // Backpressure on beat 1.
    snap(d_basic, 4'd0, 1'b0);
    @(posedge clk); #1;
    data_rdy  = 1'b0;
    held_data = data;
    held_last = data_last;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_data", 64'(data), 64'(held_data));
      chk("stall_last", 64'(data_last), 64'(held_last));
      chk("stall_vld",  64'(data_vld), 64'd1);
    end
    data_rdy = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("stall_done_busy", 64'(busy), 64'd0);

    // Collisions: drop during beat 2, recapture on the beat-3 handshake.
    snap(d_basic, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    acc_result = d_basic;
    acc_done   = 1'b1;
    #2;
    chk("coll_b2_clear", 64'(acc_clear), 64'd0);
    @(posedge clk); #1;
    chk("coll_drop", 64'(drop), 64'd1);
    chk("coll_b3_last", 64'(data_last), 64'd1);
    acc_result = d_round;
    shift      = 4'd1;
    relu_en    = 1'b0;
    #2;
    chk("coll_b3_clear", 64'(acc_clear), 64'd1);
    @(posedge clk); #1;
    acc_done = 1'b0;
    chk("coll_recap_vld",  64'(data_vld), 64'd1);
    chk("coll_recap_last", 64'(data_last), 64'd0);
    chk("coll_recap_l0",   64'(data[7:0]), 64'h7F);
    chk("coll_drop_pulse", 64'(drop), 64'd0);

    // Reset in the middle of a drain.
    snap(d_basic, 4'd0, 1'b0);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  64'(data_vld), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    snap(d_basic, 4'd0, 1'b0);
    chk("post_rst_b0_l0", 64'(data[7:0]), 64'hF0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      data_rdy   = ($urandom_range(9) < 7);
      acc_done   = ($urandom_range(4) == 0);
      acc_result = rand_data();
      shift      = SW'($urandom);
      relu_en    = 1'($urandom);
    end
    @(posedge clk); #1;
    acc_done = 1'b0;
    data_rdy = 1'b1;
    for (int n = 0; n < 50 && busy; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("final_idle", 64'(busy), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
